// File: rtl/sram_pkg.sv
// Shared types and constants for the two-bank SRAM arbiter.
package sram_pkg;

  localparam int unsigned ADDR_W   = 21;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BANK_BIT = 20;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWrSetup,
    StWrPulse,
    StWrHold,
    StDone
  } state_e;

endpackage

// File: rtl/sram_bank_port.sv
// Registered strobes/address and tri-state data driver for one asynchronous SRAM bank.
module sram_bank_port #(
  parameter int unsigned AddrW = 20,
  parameter int unsigned DataW = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ce_i,
  input  logic             oe_i,
  input  logic             we_i,
  input  logic             drive_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [DataW-1:0] wdata_i,
  output logic [AddrW-1:0] addr_o,
  output logic             ce_n_o,
  output logic             oe_n_o,
  output logic             we_n_o,
  output logic [DataW-1:0] rdata_o,
  inout  wire  [DataW-1:0] data_io
);

  logic [AddrW-1:0] addr_q;
  logic             ce_n_q, oe_n_q, we_n_q, drive_q;

  // Synchronous active-low reset; address is held between accesses.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      drive_q <= 1'b0;
    end else begin
      if (ce_i) addr_q <= addr_i;
      ce_n_q  <= ~ce_i;
      oe_n_q  <= ~oe_i;
      we_n_q  <= ~we_i;
      drive_q <= drive_i;
    end
  end

  assign addr_o  = addr_q;
  assign ce_n_o  = ce_n_q;
  assign oe_n_o  = oe_n_q;
  assign we_n_o  = we_n_q;
  assign data_io = drive_q ? wdata_i : {DataW{1'bz}};
  assign rdata_o = data_io;

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin two-port arbiter and CE/OE/WE sequencer for the baseram/extram pair.
module sram_arbiter #(
  parameter int unsigned ADDR_W = sram_pkg::ADDR_W,
  parameter int unsigned DATA_W = sram_pkg::DATA_W
) (
  input  logic              clk_mem,
  input  logic              rst,
  input  logic [7:0]        read_wait,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_ack,
  output logic [ADDR_W-2:0] baseram_addr,
  inout  wire  [DATA_W-1:0] baseram_data,
  output logic              baseram_ce,
  output logic              baseram_oe,
  output logic              baseram_we,
  output logic [ADDR_W-2:0] extram_addr,
  inout  wire  [DATA_W-1:0] extram_data,
  output logic              extram_ce,
  output logic              extram_oe,
  output logic              extram_we
);

  import sram_pkg::*;

  localparam int unsigned SramAw = ADDR_W - 1;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              port_q, port_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic [DATA_W-1:0] base_rd, ext_rd, bus_rd;
  logic              grant_b;
  logic              act_d, wr_d, ext_sel_d;

  always_ff @(posedge clk_mem) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      port_q    <= PORT_A;
      last_q    <= PORT_B;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      port_q    <= port_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    port_d    = port_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    bus_rd    = addr_q[BANK_BIT] ? ext_rd : base_rd;
    // Under contention the port that did not win last time gets the bus.
    if (a_req && b_req) grant_b = (last_q == PORT_A);
    else                grant_b = b_req;

    case (state_q)
      StIdle: begin
        if (a_req || b_req) begin
          port_d  = grant_b ? PORT_B : PORT_A;
          last_d  = grant_b ? PORT_B : PORT_A;
          addr_d  = grant_b ? b_addr : a_addr;
          wdata_d = b_wdata;
          cnt_d   = read_wait;
          state_d = (grant_b && b_we) ? StWrSetup : StRd;
        end
      end
      StRd: begin
        if (cnt_q == 8'd0) begin
          if (port_q == PORT_B) b_rdata_d = bus_rd;
          else                  a_rdata_d = bus_rd;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StWrSetup: state_d = StWrPulse;
      StWrPulse: begin
        if (cnt_q == 8'd0) state_d = StWrHold;
        else               cnt_d   = cnt_q - 8'd1;
      end
      StWrHold: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Bank controls are decoded from the next state so the pins line up with state_q.
  assign act_d     = (state_d == StRd) || (state_d == StWrSetup) ||
                     (state_d == StWrPulse) || (state_d == StWrHold);
  assign wr_d      = (state_d == StWrSetup) || (state_d == StWrPulse) || (state_d == StWrHold);
  assign ext_sel_d = addr_d[BANK_BIT];

  sram_bank_port #(
    .AddrW (SramAw),
    .DataW (DATA_W)
  ) u_base (
    .clk_i   (clk_mem),
    .rst_ni  (rst),
    .ce_i    (act_d & ~ext_sel_d),
    .oe_i    ((state_d == StRd) & ~ext_sel_d),
    .we_i    ((state_d == StWrPulse) & ~ext_sel_d),
    .drive_i (wr_d & ~ext_sel_d),
    .addr_i  (addr_d[SramAw-1:0]),
    .wdata_i (wdata_q),
    .addr_o  (baseram_addr),
    .ce_n_o  (baseram_ce),
    .oe_n_o  (baseram_oe),
    .we_n_o  (baseram_we),
    .rdata_o (base_rd),
    .data_io (baseram_data)
  );

  sram_bank_port #(
    .AddrW (SramAw),
    .DataW (DATA_W)
  ) u_ext (
    .clk_i   (clk_mem),
    .rst_ni  (rst),
    .ce_i    (act_d & ext_sel_d),
    .oe_i    ((state_d == StRd) & ext_sel_d),
    .we_i    ((state_d == StWrPulse) & ext_sel_d),
    .drive_i (wr_d & ext_sel_d),
    .addr_i  (addr_d[SramAw-1:0]),
    .wdata_i (wdata_q),
    .addr_o  (extram_addr),
    .ce_n_o  (extram_ce),
    .oe_n_o  (extram_oe),
    .we_n_o  (extram_we),
    .rdata_o (ext_rd),
    .data_io (extram_data)
  );

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
  assign a_ack   = (state_q == StDone) && (port_q == PORT_A);
  assign b_ack   = (state_q == StDone) && (port_q == PORT_B);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small behavioural model of both SRAMs.
module tb_sram_arbiter;

  logic        clk_mem = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  read_wait = '0;
  logic        a_req = 1'b0;
  logic [20:0] a_addr = '0;
  logic [31:0] a_rdata;
  logic        a_ack;
  logic        b_req = 1'b0;
  logic        b_we = 1'b0;
  logic [20:0] b_addr = '0;
  logic [31:0] b_wdata = '0;
  logic [31:0] b_rdata;
  logic        b_ack;
  logic [19:0] baseram_addr, extram_addr;
  wire  [31:0] baseram_data, extram_data;
  logic        baseram_ce, baseram_oe, baseram_we;
  logic        extram_ce, extram_oe, extram_we;

  int n_checks = 0;
  int n_fail = 0;

  always #10 clk_mem = ~clk_mem;

  sram_arbiter dut (
    .clk_mem      (clk_mem),
    .rst          (rst),
    .read_wait    (read_wait),
    .a_req        (a_req),
    .a_addr       (a_addr),
    .a_rdata      (a_rdata),
    .a_ack        (a_ack),
    .b_req        (b_req),
    .b_we         (b_we),
    .b_addr       (b_addr),
    .b_wdata      (b_wdata),
    .b_rdata      (b_rdata),
    .b_ack        (b_ack),
    .baseram_addr (baseram_addr),
    .baseram_data (baseram_data),
    .baseram_ce   (baseram_ce),
    .baseram_oe   (baseram_oe),
    .baseram_we   (baseram_we),
    .extram_addr  (extram_addr),
    .extram_data  (extram_data),
    .extram_ce    (extram_ce),
    .extram_oe    (extram_oe),
    .extram_we    (extram_we)
  );

  // SRAM model: 256 words per bank, preloaded while reset is held.
  logic [31:0] mem_base [256];
  logic [31:0] mem_ext  [256];

  assign baseram_data = (!baseram_ce && !baseram_oe) ? mem_base[baseram_addr[7:0]] : 32'bz;
  assign extram_data  = (!extram_ce && !extram_oe) ? mem_ext[extram_addr[7:0]] : 32'bz;

  always @(posedge clk_mem) begin
    if (!rst) begin
      mem_base[8'h10] <= 32'hDEAD_BEEF;
      mem_ext[8'h30]  <= 32'hCAFE_F00D;
    end else begin
      if (!baseram_ce && !baseram_we) mem_base[baseram_addr[7:0]] <= baseram_data;
      if (!extram_ce && !extram_we)   mem_ext[extram_addr[7:0]]   <= extram_data;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_mem);
    @(negedge clk_mem);
  endtask

  // Issue one access, watch it to its ack; latency counted in edges after the grant edge.
  task automatic run_access(input logic pb, input logic wr, input logic [20:0] addr,
                            input logic [31:0] wd, input logic [7:0] rw, input logic [7:0] rw_mid,
                            output int lat, output int ce_lo, output int oe_lo, output int we_lo,
                            output int oth_lo, output logic [31:0] rd, output logic [31:0] wbus);
    logic bank;
    bank = addr[20];
    lat = -1; ce_lo = 0; oe_lo = 0; we_lo = 0; oth_lo = 0; rd = '0; wbus = '0;
    read_wait = rw;
    if (pb) begin
      b_req = 1'b1; b_we = wr; b_addr = addr; b_wdata = wd;
    end else begin
      a_req = 1'b1; a_addr = addr;
    end
    for (int j = 1; j <= 400; j++) begin
      tick();
      if (j == 1) read_wait = rw_mid;
      if (bank) begin
        if (!extram_ce) ce_lo++;
        if (!extram_oe) oe_lo++;
        if (!extram_we) begin we_lo++; wbus = extram_data; end
        if (!baseram_ce) oth_lo++;
      end else begin
        if (!baseram_ce) ce_lo++;
        if (!baseram_oe) oe_lo++;
        if (!baseram_we) begin we_lo++; wbus = baseram_data; end
        if (!extram_ce) oth_lo++;
      end
      if ((pb && b_ack) || (!pb && a_ack)) begin
        lat = j;
        rd = pb ? b_rdata : a_rdata;
        break;
      end
    end
    a_req = 1'b0; b_req = 1'b0; b_we = 1'b0;
    tick();
  endtask

  initial begin
    int lat, ce_lo, oe_lo, we_lo, oth_lo, nack, dbl;
    logic [31:0] rd, wbus;
    logic seq [8];
    logic pa, pbk;

    rst = 1'b0;
    @(negedge clk_mem);
    tick();
    tick();
    check_eq("rst_strobes", {baseram_ce, baseram_oe, baseram_we, extram_ce, extram_oe, extram_we},
             32'h3F);
    check_eq("rst_acks", {a_ack, b_ack}, 32'h0);
    check_eq("rst_addr", {baseram_addr, extram_addr}, 32'h0);
    check_eq("rst_a_rdata", a_rdata, 32'h0);
    check_eq("rst_b_rdata", b_rdata, 32'h0);
    rst = 1'b1;
    tick();

    // Single A read, read_wait=2.
    run_access(1'b0, 1'b0, 21'h00010, 32'h0, 8'd2, 8'd2, lat, ce_lo, oe_lo, we_lo, oth_lo, rd, wbus);
    check_eq("t1_lat", lat, 32'd4);
    check_eq("t1_ce_lo", ce_lo, 32'd3);
    check_eq("t1_oe_lo", oe_lo, 32'd3);
    check_eq("t1_we_lo", we_lo, 32'd0);
    check_eq("t1_ext_idle", oth_lo, 32'd0);
    check_eq("t1_rdata", rd, 32'hDEAD_BEEF);

    // B write then read back on extram, read_wait=0.
    run_access(1'b1, 1'b1, 21'h100020, 32'h1234_5678, 8'd0, 8'd0, lat, ce_lo, oe_lo, we_lo,
               oth_lo, rd, wbus);
    check_eq("t2w_lat", lat, 32'd4);
    check_eq("t2w_ce_lo", ce_lo, 32'd3);
    check_eq("t2w_we_lo", we_lo, 32'd1);
    check_eq("t2w_oe_lo", oe_lo, 32'd0);
    check_eq("t2w_bus", wbus, 32'h1234_5678);
    check_eq("t2w_base_idle", oth_lo, 32'd0);
    check_eq("t2w_mem", mem_ext[8'h20], 32'h1234_5678);
    run_access(1'b1, 1'b0, 21'h100020, 32'h0, 8'd0, 8'd0, lat, ce_lo, oe_lo, we_lo, oth_lo, rd, wbus);
    check_eq("t2r_lat", lat, 32'd2);
    check_eq("t2r_rdata", rd, 32'h1234_5678);
    check_eq("t2r_a_hold", a_rdata, 32'hDEAD_BEEF);

    // read_wait changed 3 -> 0 after the grant.
    run_access(1'b0, 1'b0, 21'h00010, 32'h0, 8'd3, 8'd0, lat, ce_lo, oe_lo, we_lo, oth_lo, rd, wbus);
    check_eq("t4_lat", lat, 32'd5);
    check_eq("t4_oe_lo", oe_lo, 32'd4);
    run_access(1'b0, 1'b0, 21'h00010, 32'h0, 8'd0, 8'd0, lat, ce_lo, oe_lo, we_lo, oth_lo, rd, wbus);
    check_eq("t4_next_lat", lat, 32'd2);
    check_eq("t4_next_oe_lo", oe_lo, 32'd1);

    // Maximum wait, no counter wrap.
    run_access(1'b0, 1'b0, 21'h100030, 32'h0, 8'd255, 8'd255, lat, ce_lo, oe_lo, we_lo, oth_lo,
               rd, wbus);
    check_eq("t5_lat", lat, 32'd257);
    check_eq("t5_oe_lo", oe_lo, 32'd256);
    check_eq("t5_rdata", rd, 32'hCAFE_F00D);

    // Reset during WR_PULSE.
    read_wait = 8'd5; b_req = 1'b1; b_we = 1'b1; b_addr = 21'h00040; b_wdata = 32'hAAAA_5555;
    tick(); tick(); tick();
    check_eq("t6_in_pulse", {baseram_ce, baseram_we}, 32'h0);
    rst = 1'b0; b_req = 1'b0; b_we = 1'b0;
    tick();
    check_eq("t6_strobes", {baseram_ce, baseram_oe, baseram_we, extram_ce, extram_oe, extram_we},
             32'h3F);
    check_eq("t6_ack", {a_ack, b_ack}, 32'h0);
    rst = 1'b1;
    nack = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (a_ack || b_ack) nack++;
    end
    check_eq("t6_no_ack", nack, 32'd0);

    // Continuous contention from reset: A first, then alternating.
    read_wait = 8'd0; a_addr = 21'h00010; b_addr = 21'h100020; b_we = 1'b0;
    a_req = 1'b1; b_req = 1'b1;
    nack = 0; dbl = 0; pa = 1'b0; pbk = 1'b0;
    for (int i = 0; i < 8; i++) seq[i] = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (a_ack && b_ack) dbl++;
      if ((a_ack && pa) || (b_ack && pbk)) dbl++;
      if ((a_ack || b_ack) && nack < 8) begin
        seq[nack] = b_ack;
        nack++;
      end
      pa = a_ack; pbk = b_ack;
    end
    a_req = 1'b0; b_req = 1'b0;
    tick(); tick();
    check_eq("t3_nack", (nack >= 6) ? 32'd1 : 32'd0, 32'd1);
    check_eq("t3_order", {28'h0, seq[0], seq[1], seq[2], seq[3]}, 32'h5);
    check_eq("t3_pulse", dbl, 32'd0);
    check_eq("t3_a_rdata", a_rdata, 32'hDEAD_BEEF);
    check_eq("t3_b_rdata", b_rdata, 32'h1234_5678);

    // Plain access after the mid-write reset.
    run_access(1'b0, 1'b0, 21'h00010, 32'h0, 8'd1, 8'd1, lat, ce_lo, oe_lo, we_lo, oth_lo, rd, wbus);
    check_eq("t7_lat", lat, 32'd3);
    check_eq("t7_oe_lo", oe_lo, 32'd2);
    check_eq("t7_rdata", rd, 32'hDEAD_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
